// File: rtl/y86_imem_loader_pkg.sv
// Shared constants for the Y86 instruction-memory loader: state encodings, frame header size
// and imem geometry common to the fetch stage and imem.
package y86_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    localparam int HDR_LEN     = 2;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    // Largest payload that fits between the base address and the top of imem.
    function automatic int max_len(input int addr_w, input int base_addr);
        return (1 << addr_w) - base_addr;
    endfunction

endpackage

// File: rtl/y86_imem_loader.sv
// Streams a length-prefixed Y86 program image into byte-wide imem, then releases the core.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | waiting for low byte of payload length
// LEN_HI | waiting for high byte; length checked against imem space
// DATA   | each accepted byte written to imem one cycle later
// CSUM   | waiting for XOR checksum byte (LOADER_CHECKSUM_EN only)
// DONE   | image loaded, core_run high
// ERR    | oversize length or checksum mismatch, sticky until start/reset
module y86_imem_loader
    import y86_imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_run,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int                MAX_LEN = max_len(ADDR_W, BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t ST_POST = ST_CSUM;
`else
    localparam loader_state_t ST_POST = ST_DONE;
`endif

    loader_state_t   state;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic            xfer;
    logic [15:0]     len_hdr;
    logic            len_too_big;
    logic [ADDR_W:0] count_nxt;
    logic            last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign busy     = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CSUM);
    assign s_ready  = busy;
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);
    assign core_run = (state == ST_DONE);

    assign xfer        = s_valid & s_ready;
    assign len_hdr     = {s_data, len_lo};
    assign len_too_big = 32'(len_hdr) > 32'(MAX_LEN);
    assign count_nxt   = bytes_loaded + 1'b1;
    assign last_byte   = (32'(count_nxt) == 32'(len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            len_lo       <= '0;
            len          <= '0;
            bytes_loaded <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_LEN_LO;
                        len_lo       <= '0;
                        len          <= '0;
                        bytes_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= s_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len <= len_hdr;
                        if (len_too_big)
                            state <= ST_ERR;
                        else if (len_hdr == 16'd0)
                            state <= ST_POST;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= BASE + bytes_loaded[ADDR_W-1:0];
                        mem_wdata    <= s_data;
                        bytes_loaded <= count_nxt;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= csum ^ s_data;
`endif
                        if (last_byte)
                            state <= ST_POST;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer)
                        state <= (s_data == csum) ? ST_DONE : ST_ERR;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_loader.sv
// Directed self-checking bench for y86_imem_loader (default ADDR_W=10, BASE_ADDR=0).
module tb_y86_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_run;
    logic [10:0] bytes_loaded;

    int checks   = 0;
    int failures = 0;

    logic [9:0] wr_addr [$];
    logic [7:0] wr_data [$];

    y86_imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .core_run     (core_run),
        .bytes_loaded (bytes_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every imem write seen during the cycle before each rising edge.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: s_ready=%b required 1 byte=%h", s_ready, b);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, busy, done, err, core_run, s_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000",
                     {mem_we, busy, done, err, core_run, s_ready});
        end
        checks++;
        if (mem_addr !== 10'd0 || mem_wdata !== 8'd0 || bytes_loaded !== 11'd0) begin
            failures++;
            $display("FAIL reset_values: addr=%h wdata=%h bytes=%0d required 0",
                     mem_addr, mem_wdata, bytes_loaded);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_with_valid();
        clear_log();
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h05;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_s_ready: got %b required 0", s_ready);
        end
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy: got %b required 1", busy);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAA);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'd0 || wr_data[0] !== 8'hAA) begin
            failures++;
            $display("FAIL start_valid_write: count=%0d addr0=%h data0=%h required 1/000/aa",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff,
                     (wr_data.size() > 0) ? wr_data[0] : 8'hxx);
        end
        checks++;
        if (done !== 1'b1 || core_run !== 1'b1 || bytes_loaded !== 11'd1) begin
            failures++;
            $display("FAIL start_valid_done: done=%b run=%b bytes=%0d required 1/1/1",
                     done, core_run, bytes_loaded);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        exp_d = '{8'h30, 8'hF2, 8'h0A};
        clear_log();
        pulse_start();
        checks++;
        if (core_run !== 1'b0 || done !== 1'b0 || bytes_loaded !== 11'd0) begin
            failures++;
            $display("FAIL restart_clear: run=%b done=%b bytes=%0d required 0/0/0",
                     core_run, done, bytes_loaded);
        end
        send_byte(8'h03);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_while_busy: busy=%b s_ready=%b required 1/1", busy, s_ready);
        end
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_byte(exp_d[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hC8);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("FAIL basic_count: got %0d required 3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL basic_write%0d: addr=%h data=%h required %h/%h",
                             i, wr_addr[i], wr_data[i], 10'(i), exp_d[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || core_run !== 1'b1 || err !== 1'b0 || bytes_loaded !== 11'd3) begin
            failures++;
            $display("FAIL basic_done: done=%b run=%b err=%b bytes=%0d required 1/1/0/3",
                     done, core_run, err, bytes_loaded);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_log();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(exp_d[i]);
            @(negedge clk);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h44);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 4) begin
            failures++;
            $display("FAIL gaps_count: got %0d required 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL gaps_write%0d: addr=%h data=%h required %h/%h",
                             i, wr_addr[i], wr_data[i], 10'(i), exp_d[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || bytes_loaded !== 11'd4) begin
            failures++;
            $display("FAIL gaps_done: done=%b bytes=%0d required 1/4", done, bytes_loaded);
        end
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || core_run !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL oversize_err: err=%b done=%b busy=%b run=%b rdy=%b required 1/0/0/0/0",
                     err, done, busy, core_run, s_ready);
        end
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL oversize_sticky: writes=%0d err=%b required 0/1", wr_addr.size(), err);
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL maxlen_accept: busy=%b err=%b required 1/0", busy, err);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        s_valid = 1'b1;
        s_data  = 8'h33;
        #2;
        rst_n = 1'b0;
        #1;
        clear_log();
        checks++;
        if ({mem_we, busy, done, err, core_run, s_ready} !== 6'b0 || bytes_loaded !== 11'd0) begin
            failures++;
            $display("FAIL midload_reset: flags=%b bytes=%0d required 000000/0",
                     {mem_we, busy, done, err, core_run, s_ready}, bytes_loaded);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0) begin
                failures++;
                $display("FAIL midload_no_we%0d: got %b required 0", i, mem_we);
            end
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_addr.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midload_idle: writes=%0d busy=%b required 0/0", wr_addr.size(), busy);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || core_run !== 1'b1 || bytes_loaded !== 11'd0 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_len: done=%b run=%b bytes=%0d writes=%0d required 1/1/0/0",
                     done, core_run, bytes_loaded, wr_addr.size());
        end
        pulse_start();
        checks++;
        if (core_run !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || bytes_loaded !== 11'd0) begin
            failures++;
            $display("FAIL zero_restart: run=%b done=%b busy=%b bytes=%0d required 0/0/1/0",
                     core_run, done, busy, bytes_loaded);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_err();
        clear_log();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'hF2);
        send_byte(8'h0A);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || core_run !== 1'b0 || wr_addr.size() != 3) begin
            failures++;
            $display("FAIL csum_err: err=%b done=%b run=%b writes=%0d required 1/0/0/3",
                     err, done, core_run, wr_addr.size());
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_start_with_valid();
        test_basic();
        test_gaps();
        test_oversize();
        test_reset_mid_load();
        test_zero_len();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
